// File: rtl/sram_dp.sv
// sram_dp: dual-port RAM (port A read/write, port B read-only) with an FSM that fills the array with CLEAR_VALUE
module sram_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int WRITE_FIRST = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] b_a,
  output logic [DATA_W-1:0] b_out,
  input  logic              clr,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] cnt;
  logic pend, wr, last, nbusy;
  assign busy = state == CLEAR;
  always_comb begin
    wr = !cs && !we && !busy;
    last = cnt == '1;
    nbusy = busy ? !last : (pend || clr);
  end
  always_ff @(posedge clk)
    if (busy) ram[cnt] <= CLEAR_VALUE;
    else if (wr) ram[a] <= in;
  // Outputs are zeroed on the edge that enters busy, so they read 0 for the whole sequence.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend <= CLEAR_ON_RESET != 0;
      out <= '0;
      b_out <= '0;
    end else begin
      pend <= 1'b0;
      state <= nbusy ? CLEAR : IDLE;
      cnt <= (busy && !last) ? cnt + 1'b1 : '0;
      out <= nbusy ? '0 : (WRITE_FIRST != 0 && wr) ? in : ram[a];
      b_out <= nbusy ? '0 : ram[b_a];
    end
endmodule

// File: doc/sram_dp.md
SRAM_DP -- requirements
Module: sram_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 13, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter WRITE_FIRST, default 0; 0 = port A read-before-write, 1 = port A write-through.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = clear sequence starts on reset release.
REQ-005 SHALL have parameter CLEAR_VALUE, default 0, DATA_W-bit fill value for clear sequence.
REQ-006 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port a  input  ADDR_W  port A (CPU) address.
REQ-009 SHALL have port in  input  DATA_W  port A write data.
REQ-010 SHALL have port out  output  DATA_W  port A registered read data.
REQ-011 SHALL have port cs  input  1  port A chip select, active-low.
REQ-012 SHALL have port we  input  1  port A write enable, active-low.
REQ-013 SHALL have port b_a  input  ADDR_W  port B (video/debug) read address.
REQ-014 SHALL have port b_out  output  DATA_W  port B registered read data.
REQ-015 SHALL have port clr  input  1  active-high request to start a clear sequence.
REQ-016 SHALL have port busy  output  1  high while clear sequence in progress.

Function
REQ-017 Port A write: cs==0 && we==0 && busy==0 at rising edge SHALL store in at ram[a].
REQ-018 Port A read: out SHALL update every edge from ram[a], latency 1 cycle, independent of cs.
REQ-019 Same-cycle port A write to a: WRITE_FIRST=0 SHALL give out = old ram[a]; WRITE_FIRST=1 SHALL give out = in.
REQ-020 Port B SHALL be read-only; b_out updates every edge from ram[b_a], latency 1 cycle.
REQ-021 b_a equal to a port A write address in the same cycle SHALL give b_out = old contents.
REQ-022 Clear FSM SHALL have two states: IDLE (busy=0) and CLEAR (busy=1).
REQ-023 IDLE -> CLEAR SHALL occur on an edge with clr==1, or on the first edge after reset release when CLEAR_ON_RESET==1; the clear counter is set to 0.
REQ-024 In CLEAR, each edge SHALL write CLEAR_VALUE to ram[counter] and increment counter (ADDR_W bits).
REQ-025 CLEAR -> IDLE SHALL occur on the edge that writes address DEPTH-1; total sequence exactly DEPTH cycles with busy high.
REQ-026 clr asserted while in CLEAR SHALL be ignored; sequence is not restarted.
REQ-027 While busy==1, port A writes SHALL be dropped (no side effect), out and b_out SHALL be forced to 0.
REQ-028 Counter wrap past DEPTH-1 SHALL NOT occur; the FSM leaves CLEAR first.
REQ-029 Memory contents SHALL NOT be modified by reset itself; only by port A writes or the clear sequence.

Reset
REQ-030 While reset==1: out=0, b_out=0, counter=0, FSM=IDLE, busy=0, regardless of clk.
REQ-031 reset asserted mid-clear SHALL abort the sequence; with CLEAR_ON_RESET==1 a full sequence from address 0 restarts after release.
REQ-032 With CLEAR_ON_RESET==0, busy SHALL stay 0 after reset until clr is asserted.

Verification (bench: DATA_W=8, ADDR_W=4, CLEAR_VALUE=8'hA5)
REQ-033 Reset pulse, CLEAR_ON_RESET=1 -> busy high for exactly 16 cycles; afterwards reads of all 16 addresses return 8'hA5 on both ports.
REQ-034 Write 8'h3C to a=4'h7 (cs=0, we=0); read a=7 next cycle -> out=8'h3C one cycle later; b_a=7 -> b_out=8'h3C.
REQ-035 ram[5]=8'h11, write 8'h22 to a=5 with b_a=5 in same cycle -> b_out=8'h11; out=8'h11 (WRITE_FIRST=0) or 8'h22 (WRITE_FIRST=1).
REQ-036 Write attempt (a=2, in=8'hFF) during busy -> dropped; after clear ram[2] reads 8'hA5; out/b_out read 0 while busy.
REQ-037 Assert reset at clear cycle 8, release -> busy restarts, high 16 cycles; clr pulse during busy -> no extension.
REQ-038 cs=1, we=0, a=3, in=8'h55 -> no write; ram[3] unchanged.
